// File: rtl/timer_bank_if.sv
// rtl/timer_bank_if.sv - native memory bus bundle between CPU master and timer_bank
interface timer_bank_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output valid, wstrb, addr, wdata, input ready, rdata);
    modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - CHANNELS independent WIDTH-bit compare timers with sticky wrap flags and irq
module timer_bank #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 32
) (
    input  logic                clk,
    input  logic                resetn,
    timer_bank_if.slave         bus,
    output logic [CHANNELS-1:0] tick,
    output logic                irq
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_MAX    = 2'd1;
    localparam logic [1:0] REG_CNT    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] oneshot;
    logic [CHANNELS-1:0] ie;
    logic [CHANNELS-1:0] flag;
    logic [WIDTH-1:0]    max_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_q [CHANNELS];

    logic                accept;
    logic                wr;
    logic [2:0]          ch;
    logic [1:0]          rsel;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] sel;
    logic [31:0]         rd_data;
    logic                unused_addr;

    assign accept      = bus.valid & ~bus.ready;
    assign wr          = accept & (|bus.wstrb);
    assign ch          = bus.addr[6:4];
    assign rsel        = bus.addr[3:2];
    assign unused_addr = ^{bus.addr[31:7], bus.addr[1:0]};
    assign irq         = |(flag & ie);

    // Byte-lane merge into a field; lanes beyond WIDTH fall away on truncation.
    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                               input logic [3:0] ws,
                                               input logic [31:0] wd);
        logic [31:0] m;
        m = 32'(old);
        for (int n = 0; n < 4; n++) begin
            if (ws[n]) m[8*n +: 8] = wd[8*n +: 8];
        end
        return m[WIDTH-1:0];
    endfunction

    always_comb begin
        wrap = '0;
        sel  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wrap[i] = en[i] && (cnt_q[i] == max_q[i]);
            sel[i]  = wr && (ch == 3'(i));
        end
    end

    // Channels outside CHANNELS never match, so they read 0 and ignore writes.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch == 3'(i)) begin
                case (rsel)
                    REG_CTRL:   rd_data = {29'd0, ie[i], oneshot[i], en[i]};
                    REG_MAX:    rd_data = 32'(max_q[i]);
                    REG_CNT:    rd_data = 32'(cnt_q[i]);
                    default:    rd_data = {31'd0, flag[i]};
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.ready <= 1'b0;
            bus.rdata <= '0;
            tick      <= '0;
            en        <= '0;
            oneshot   <= '0;
            ie        <= '0;
            flag      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                max_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            bus.ready <= accept;
            bus.rdata <= accept ? rd_data : 32'd0;
            tick      <= wrap;
            for (int i = 0; i < CHANNELS; i++) begin
                if (en[i]) cnt_q[i] <= wrap[i] ? '0 : cnt_q[i] + WIDTH'(1);
                if (wrap[i] && oneshot[i]) en[i] <= 1'b0;

                // A wrap on the same edge beats a write-1-clear.
                if (wrap[i])
                    flag[i] <= 1'b1;
                else if (sel[i] && rsel == REG_STATUS && bus.wstrb[0] && bus.wdata[0])
                    flag[i] <= 1'b0;

                // Bus writes come last so they override the counting update above.
                if (sel[i]) begin
                    case (rsel)
                        REG_CTRL: begin
                            if (bus.wstrb[0]) begin
                                en[i]      <= bus.wdata[0];
                                oneshot[i] <= bus.wdata[1];
                                ie[i]      <= bus.wdata[2];
                            end
                        end
                        REG_MAX: max_q[i] <= merge(max_q[i], bus.wstrb, bus.wdata);
                        REG_CNT: cnt_q[i] <= merge(cnt_q[i], bus.wstrb, bus.wdata);
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - randomized scoreboard bench for timer_bank against a behavioural model
module tb_timer_bank;
    localparam int CH = 2;
    localparam int W  = 16;
    localparam longint MOD = longint'(1) << W;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [CH-1:0] tick;
    logic          irq;

    timer_bank_if bus ();

    timer_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .tick   (tick),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit mon_on = 1'b0;

    // Behavioural model state
    bit          m_en [CH];
    bit          m_os [CH];
    bit          m_ie [CH];
    bit          m_flag [CH];
    longint      m_max [CH];
    longint      m_cnt [CH];
    bit          exp_ready = 1'b0;
    bit [CH-1:0] exp_tick = '0;
    bit          exp_irq = 1'b0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] ad(input int c, input int r);
        return 32'(c * 16 + r * 4);
    endfunction

    function automatic logic [31:0] rd_value(input bit [31:0] a);
        int c = int'(a[6:4]);
        if (c >= CH) return 32'd0;
        case (a[3:2])
            2'd0:    return {29'd0, m_ie[c], m_os[c], m_en[c]};
            2'd1:    return 32'(m_max[c]);
            2'd2:    return 32'(m_cnt[c]);
            default: return {31'd0, m_flag[c]};
        endcase
    endfunction

    function automatic longint merge(input longint old, input bit [3:0] ws, input bit [31:0] wd);
        bit [31:0] v = old[31:0];
        for (int n = 0; n < 4; n++)
            if (ws[n]) v[8*n +: 8] = wd[8*n +: 8];
        return longint'(v) % MOD;
    endfunction

    // One clock edge of the timer as described: compare on the old count, then bus write wins.
    task automatic model_step(input bit rst, input bit v, input bit [3:0] ws,
                              input bit [31:0] a, input bit [31:0] wd);
        bit acc;
        bit wrap [CH];
        longint old_cnt;
        int c;
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                m_en[i] = 0; m_os[i] = 0; m_ie[i] = 0; m_flag[i] = 0;
                m_max[i] = 0; m_cnt[i] = 0;
            end
            exp_ready = 0;
            exp_tick  = '0;
        end else begin
            acc = v && !exp_ready;
            if (acc) exp_q.push_back(rd_value(a));
            c = int'(a[6:4]);
            for (int i = 0; i < CH; i++) begin
                old_cnt = m_cnt[i];
                wrap[i] = m_en[i] && (m_cnt[i] == m_max[i]);
                if (m_en[i]) m_cnt[i] = wrap[i] ? 0 : (m_cnt[i] + 1) % MOD;
                if (wrap[i]) begin
                    m_flag[i] = 1;
                    if (m_os[i]) m_en[i] = 0;
                end
                if (acc && ws != 0 && c == i) begin
                    case (a[3:2])
                        2'd0: if (ws[0]) begin
                            m_en[i] = wd[0]; m_os[i] = wd[1]; m_ie[i] = wd[2];
                        end
                        2'd1: m_max[i] = merge(m_max[i], ws, wd);
                        2'd2: m_cnt[i] = merge(old_cnt, ws, wd);
                        default: if (ws[0] && wd[0] && !wrap[i]) m_flag[i] = 0;
                    endcase
                end
                exp_tick[i] = wrap[i];
            end
            exp_ready = acc;
        end
        exp_irq = 0;
        for (int i = 0; i < CH; i++) exp_irq |= m_flag[i] & m_ie[i];
    endtask

    task automatic cyc(input bit rst, input bit v, input bit [3:0] ws,
                       input bit [31:0] a, input bit [31:0] wd);
        @(negedge clk);
        resetn    = rst;
        bus.valid = v;
        bus.wstrb = ws;
        bus.addr  = a;
        bus.wdata = wd;
        @(posedge clk);
        model_step(rst, v, ws, a, wd);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1, 0, 4'h0, 32'd0, 32'd0);
    endtask

    task automatic access(input bit [3:0] ws, input bit [31:0] a, input bit [31:0] wd);
        cyc(1, 1, ws, a, wd);
        cyc(1, 0, 4'h0, 32'd0, 32'd0);
    endtask

    task automatic wr(input int c, input int r, input bit [31:0] d);
        access(4'hF, ad(c, r), d);
    endtask

    task automatic rd(input int c, input int r);
        access(4'h0, ad(c, r), 32'd0);
    endtask

    // Monitor: compares DUT outputs with the model and pops the scoreboard on each ready.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("ready", 32'(bus.ready), 32'(exp_ready));
            if (bus.ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rdata_unexpected: got %0h required no response", bus.rdata);
                end else begin
                    chk("rdata", bus.rdata, exp_q.pop_front());
                end
            end else begin
                chk("rdata_idle", bus.rdata, 32'd0);
            end
            chk("tick", 32'(tick), 32'(exp_tick));
            chk("irq", 32'(irq), 32'(exp_irq));
        end
    end

    initial begin
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;
        cyc(0, 0, 4'h0, 32'd0, 32'd0);
        mon_on = 1'b1;
        cyc(0, 0, 4'h0, 32'd0, 32'd0);
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < 4; r++) rd(c, r);

        // Periodic mode with flag clear and re-wrap
        wr(0, 1, 3);
        wr(0, 0, 5);
        for (int k = 0; k < 4; k++) rd(0, 2);
        idle(6);
        wr(0, 3, 1);
        idle(6);
        rd(0, 3);

        // One-shot mode
        wr(1, 1, 5);
        wr(1, 0, 3);
        idle(14);
        rd(1, 0);
        rd(1, 2);
        rd(1, 3);

        // Byte strobes and truncation above WIDTH
        wr(0, 0, 0);
        wr(0, 1, 0);
        access(4'b0010, ad(0, 1), 32'hAABBCCDD);
        rd(0, 1);
        access(4'b0100, ad(0, 1), 32'hAABBCCDD);
        rd(0, 1);
        wr(0, 1, 32'hFFFFFFFF);
        rd(0, 1);

        // Writes landing on every phase of a wrap, including the wrap edge itself
        for (int d = 0; d < 5; d++) begin
            wr(0, 0, 0); wr(0, 1, 3); wr(0, 2, 0); wr(0, 3, 1); wr(0, 0, 5);
            idle(d);
            wr(0, 3, 1);
            rd(0, 3);
            idle(d);
            wr(0, 2, 7);
            rd(0, 2);
        end

        // MAX=0 wraps every cycle
        wr(1, 0, 0); wr(1, 1, 0); wr(1, 2, 0); wr(1, 0, 1);
        idle(4);
        rd(1, 2);
        wr(1, 0, 0);

        // MAX below count: roll over through 2^W-1 without tick
        wr(1, 1, 3); wr(1, 2, 32'h0000FFFC); wr(1, 0, 1);
        idle(10);
        wr(1, 0, 0);

        // Out-of-range channel and valid held across ready
        rd(7, 0);
        wr(5, 1, 32'h1234);
        rd(5, 1);
        for (int k = 0; k < 4; k++) cyc(1, 1, 4'h0, ad(0, 1), 32'd0);
        idle(1);

        // Reset mid-count
        wr(0, 1, 10); wr(0, 2, 0); wr(0, 0, 5);
        idle(1);
        cyc(0, 0, 4'h0, 32'd0, 32'd0);
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < 4; r++) rd(c, r);

        // Randomized traffic
        for (int it = 0; it < 1500; it++) begin
            int sel_op = int'($urandom_range(0, 99));
            if (sel_op < 2) begin
                cyc(0, 0, 4'h0, 32'd0, 32'd0);
            end else if (sel_op < 75) begin
                int c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, 1));
                int r = int'($urandom_range(0, 3));
                bit [3:0] ws = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
                bit [31:0] d = $urandom;
                int hold = int'($urandom_range(1, 3));
                if (r == 1) d = (d & 32'hFFFF0000) | $urandom_range(0, 6);
                if (r == 2 && $urandom_range(0, 3) == 0) d = 32'hFFFF - $urandom_range(0, 3);
                if (r == 2 && $urandom_range(0, 1) == 0) d = $urandom_range(0, 6);
                for (int h = 0; h < hold; h++) cyc(1, 1, ws, ad(c, r), d);
                cyc(1, 0, 4'h0, 32'd0, 32'd0);
            end else begin
                idle(int'($urandom_range(1, 4)));
            end
        end

        idle(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
